// File: rtl/mem_stage.sv
// mem_stage: M stage of the pipelined MIPS CPU.
// Performs loads/stores against an internal word-addressed RAM whose access
// occupies the stage for MEM_LATENCY cycles, stalls upstream while an access
// is in flight, and registers results into the M->W pipeline register.
//
// Handshake: StallM high means "M has not accepted the instruction yet";
// the upstream pipeline holds every M input stable until a cycle with
// StallM low, and the instruction is consumed at that cycle's rising edge.
module mem_stage #(
    parameter int MEM_WORDS   = 256,
    parameter int MEM_LATENCY = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        RegWriteM,
    input  logic        MemtoRegM,
    input  logic        MemWriteM,
    input  logic [31:0] ALUOutM,
    input  logic [31:0] WriteDataM,
    input  logic [4:0]  WriteRegM,
    output logic        StallM,
    output logic        RegWriteW,
    output logic        MemtoRegW,
    output logic [31:0] ReadDataW,
    output logic [31:0] ALUOutW,
    output logic [4:0]  WriteRegW,
    output logic        AlignErrW,
    output logic        dbg_busy
);

    localparam int AW = $clog2(MEM_WORDS);
    localparam int CW = $clog2(MEM_LATENCY) + 1;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;

    // Data RAM: zero at power-up, deliberately untouched by reset.
    logic [31:0]     mem_q [0:MEM_WORDS-1] = '{default: 32'h0};

    logic            acc;
    logic            is_load;
    logic            misaligned;
    logic [AW-1:0]   idx;
    logic            complete;
    logic            mem_we;

    logic            reg_write_w_q, reg_write_w_d;
    logic            mem_to_reg_w_q, mem_to_reg_w_d;
    logic [31:0]     read_data_w_q, read_data_w_d;
    logic [31:0]     alu_out_w_q, alu_out_w_d;
    logic [4:0]      write_reg_w_q, write_reg_w_d;
    logic            align_err_w_q, align_err_w_d;

    // Request decode; a load+store combination is treated as a store.
    always_comb begin
        acc        = MemtoRegM | MemWriteM;
        is_load    = MemtoRegM & ~MemWriteM;
        misaligned = |ALUOutM[1:0];
        idx        = ALUOutM[AW+1:2];
    end

    // Latency FSM: StallM depends only on state, cnt and acc.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        complete = 1'b0;
        StallM   = 1'b0;
        case (state_q)
            IDLE: begin
                if (!acc || MEM_LATENCY == 1) begin
                    complete = 1'b1;
                end else begin
                    StallM  = 1'b1;
                    state_d = BUSY;
                    cnt_d   = CW'(MEM_LATENCY - 1);
                end
            end
            BUSY: begin
                if (cnt_q > CW'(1)) begin
                    StallM = 1'b1;
                    cnt_d  = cnt_q - CW'(1);
                end else begin
                    complete = 1'b1;
                    state_d  = IDLE;
                    cnt_d    = '0;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Next W-register contents: the retiring instruction or a bubble.
    always_comb begin
        reg_write_w_d  = 1'b0;
        mem_to_reg_w_d = 1'b0;
        read_data_w_d  = '0;
        alu_out_w_d    = '0;
        write_reg_w_d  = '0;
        align_err_w_d  = 1'b0;
        if (complete) begin
            reg_write_w_d  = RegWriteM & ~(is_load & misaligned);
            mem_to_reg_w_d = MemtoRegM;
            read_data_w_d  = (is_load && !misaligned) ? mem_q[idx] : '0;
            alu_out_w_d    = ALUOutM;
            write_reg_w_d  = WriteRegM;
            align_err_w_d  = acc & misaligned;
        end
    end

    // A store commits once, at its completion edge, and never while in reset.
    always_comb begin
        mem_we = complete & MemWriteM & ~misaligned & ~reset;
    end

    // FSM and M->W pipeline registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            reg_write_w_q  <= 1'b0;
            mem_to_reg_w_q <= 1'b0;
            read_data_w_q  <= '0;
            alu_out_w_q    <= '0;
            write_reg_w_q  <= '0;
            align_err_w_q  <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            reg_write_w_q  <= reg_write_w_d;
            mem_to_reg_w_q <= mem_to_reg_w_d;
            read_data_w_q  <= read_data_w_d;
            alu_out_w_q    <= alu_out_w_d;
            write_reg_w_q  <= write_reg_w_d;
            align_err_w_q  <= align_err_w_d;
        end
    end

    // Synchronous single-port RAM write.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[idx] <= WriteDataM;
        end
    end

    assign RegWriteW = reg_write_w_q;
    assign MemtoRegW = mem_to_reg_w_q;
    assign ReadDataW = read_data_w_q;
    assign ALUOutW   = alu_out_w_q;
    assign WriteRegW = write_reg_w_q;
    assign AlignErrW = align_err_w_q;
    assign dbg_busy  = (state_q == BUSY);

endmodule

// File: tb/tb_mem_stage.sv
// Directed testbench for mem_stage: three instances with latencies 2, 4, 3.
module tb_mem_stage;

    logic        clk;
    logic        reset;
    logic [2:0]  rw_m, m2r_m, mw_m;
    logic [31:0] alu_m [3];
    logic [31:0] wd_m [3];
    logic [4:0]  wr_m [3];
    logic [2:0]  stall_m, rw_w, m2r_w, ae_w, busy;
    logic [31:0] rd_w [3];
    logic [31:0] alu_w [3];
    logic [4:0]  wr_w [3];

    int tests_run;
    int tests_failed;

    mem_stage #(.MEM_WORDS(256), .MEM_LATENCY(2)) u_dut0 (
        .clk(clk), .reset(reset),
        .RegWriteM(rw_m[0]), .MemtoRegM(m2r_m[0]), .MemWriteM(mw_m[0]),
        .ALUOutM(alu_m[0]), .WriteDataM(wd_m[0]), .WriteRegM(wr_m[0]),
        .StallM(stall_m[0]), .RegWriteW(rw_w[0]), .MemtoRegW(m2r_w[0]),
        .ReadDataW(rd_w[0]), .ALUOutW(alu_w[0]), .WriteRegW(wr_w[0]),
        .AlignErrW(ae_w[0]), .dbg_busy(busy[0])
    );

    mem_stage #(.MEM_WORDS(256), .MEM_LATENCY(4)) u_dut1 (
        .clk(clk), .reset(reset),
        .RegWriteM(rw_m[1]), .MemtoRegM(m2r_m[1]), .MemWriteM(mw_m[1]),
        .ALUOutM(alu_m[1]), .WriteDataM(wd_m[1]), .WriteRegM(wr_m[1]),
        .StallM(stall_m[1]), .RegWriteW(rw_w[1]), .MemtoRegW(m2r_w[1]),
        .ReadDataW(rd_w[1]), .ALUOutW(alu_w[1]), .WriteRegW(wr_w[1]),
        .AlignErrW(ae_w[1]), .dbg_busy(busy[1])
    );

    mem_stage #(.MEM_WORDS(256), .MEM_LATENCY(3)) u_dut2 (
        .clk(clk), .reset(reset),
        .RegWriteM(rw_m[2]), .MemtoRegM(m2r_m[2]), .MemWriteM(mw_m[2]),
        .ALUOutM(alu_m[2]), .WriteDataM(wd_m[2]), .WriteRegM(wr_m[2]),
        .StallM(stall_m[2]), .RegWriteW(rw_w[2]), .MemtoRegW(m2r_w[2]),
        .ReadDataW(rd_w[2]), .ALUOutW(alu_w[2]), .WriteRegW(wr_w[2]),
        .AlignErrW(ae_w[2]), .dbg_busy(busy[2])
    );

    // Clock and reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic set_nop(input int k);
        rw_m[k] = 1'b0; m2r_m[k] = 1'b0; mw_m[k] = 1'b0;
        alu_m[k] = '0; wd_m[k] = '0; wr_m[k] = '0;
    endtask

    // Driver: presents one instruction to instance k right after a rising edge,
    // holds it while StallM is high, and returns just after its completion edge
    // with a nop on the inputs. Reports stalled cycles and non-bubble W cycles
    // seen while stalled.
    task automatic issue(input int k, input logic rw, input logic m2r, input logic mw,
                         input logic [31:0] alu, input logic [31:0] wd, input logic [4:0] wr,
                         output int stalls, output int bad);
        logic prev;
        prev   = 1'b0;
        stalls = 0;
        bad    = 0;
        @(posedge clk); #1;
        rw_m[k] = rw; m2r_m[k] = m2r; mw_m[k] = mw;
        alu_m[k] = alu; wd_m[k] = wd; wr_m[k] = wr;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            if (prev && (rw_w[k] || m2r_w[k] || ae_w[k] || rd_w[k] != 0 ||
                         alu_w[k] != 0 || wr_w[k] != 0))
                bad++;
            prev = stall_m[k];
            if (!stall_m[k]) break;
            stalls++;
        end
        @(posedge clk); #1;
        set_nop(k);
    endtask

    task automatic test_reset();
        int s, b;
        issue(0, 1'b1, 1'b0, 1'b0, 32'h55, 32'h0, 5'd7, s, b);
        @(negedge clk);
        tests_run++; if (s !== 0) begin tests_failed++; $display("FAIL alu_stall: got %0d, expected 0", s); end
        tests_run++; if ({rw_w[0], m2r_w[0], ae_w[0], alu_w[0], wr_w[0]} !== {3'b100, 32'h55, 5'd7}) begin
            tests_failed++; $display("FAIL alu_w: got rw=%b m2r=%b ae=%b alu=%h wr=%0d, expected rw=1 m2r=0 ae=0 alu=55 wr=7",
                                     rw_w[0], m2r_w[0], ae_w[0], alu_w[0], wr_w[0]); end
        #2 reset = 1'b1;
        #1;
        for (int k = 0; k < 3; k++) begin
            tests_run++;
            if ({stall_m[k], rw_w[k], m2r_w[k], ae_w[k], rd_w[k], alu_w[k], wr_w[k], busy[k]} !== '0) begin
                tests_failed++;
                $display("FAIL async_reset[%0d]: got stall=%b rw=%b m2r=%b ae=%b rd=%h alu=%h wr=%0d busy=%b, expected all 0",
                         k, stall_m[k], rw_w[k], m2r_w[k], ae_w[k], rd_w[k], alu_w[k], wr_w[k], busy[k]);
            end
        end
        @(posedge clk); #1 reset = 1'b0;
    endtask

    task automatic test_store_load();
        int s, b;
        issue(0, 1'b0, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 5'd0, s, b);
        @(negedge clk);
        tests_run++; if (s !== 1) begin tests_failed++; $display("FAIL st_stall: got %0d, expected 1", s); end
        tests_run++; if (b !== 0) begin tests_failed++; $display("FAIL st_bubble: got %0d bad cycles, expected 0", b); end
        tests_run++; if ({rw_w[0], ae_w[0]} !== 2'b00) begin tests_failed++; $display("FAIL st_w: got rw=%b ae=%b, expected 0 0", rw_w[0], ae_w[0]); end
        issue(0, 1'b1, 1'b1, 1'b0, 32'h10, 32'h0, 5'd9, s, b);
        @(negedge clk);
        tests_run++; if (s !== 1) begin tests_failed++; $display("FAIL ld_stall: got %0d, expected 1", s); end
        tests_run++; if (rd_w[0] !== 32'hDEADBEEF) begin tests_failed++; $display("FAIL ld_data: got %h, expected deadbeef", rd_w[0]); end
        tests_run++; if ({rw_w[0], m2r_w[0], wr_w[0], alu_w[0]} !== {2'b11, 5'd9, 32'h10}) begin
            tests_failed++; $display("FAIL ld_ctrl: got rw=%b m2r=%b wr=%0d alu=%h, expected 1 1 9 10",
                                     rw_w[0], m2r_w[0], wr_w[0], alu_w[0]); end
    endtask

    task automatic test_latency4();
        int s, b;
        issue(1, 1'b0, 1'b0, 1'b1, 32'h20, 32'hCAFEF00D, 5'd0, s, b);
        @(negedge clk);
        tests_run++; if (s !== 3) begin tests_failed++; $display("FAIL l4_st_stall: got %0d, expected 3", s); end
        issue(1, 1'b1, 1'b1, 1'b0, 32'h20, 32'h0, 5'd3, s, b);
        @(negedge clk);
        tests_run++; if (s !== 3) begin tests_failed++; $display("FAIL l4_ld_stall: got %0d, expected 3", s); end
        tests_run++; if (b !== 0) begin tests_failed++; $display("FAIL l4_bubble: got %0d bad cycles, expected 0", b); end
        tests_run++; if ({rd_w[1], rw_w[1], m2r_w[1], wr_w[1]} !== {32'hCAFEF00D, 2'b11, 5'd3}) begin
            tests_failed++; $display("FAIL l4_ld_w: got rd=%h rw=%b m2r=%b wr=%0d, expected cafef00d 1 1 3",
                                     rd_w[1], rw_w[1], m2r_w[1], wr_w[1]); end
    endtask

    task automatic test_misaligned();
        int s, b;
        issue(0, 1'b0, 1'b0, 1'b1, 32'h11, 32'h12345678, 5'd0, s, b);
        @(negedge clk);
        tests_run++; if (s !== 1) begin tests_failed++; $display("FAIL mis_st_stall: got %0d, expected 1", s); end
        tests_run++; if (ae_w[0] !== 1'b1) begin tests_failed++; $display("FAIL mis_st_ae: got %b, expected 1", ae_w[0]); end
        @(negedge clk);
        tests_run++; if (ae_w[0] !== 1'b0) begin tests_failed++; $display("FAIL mis_ae_clear: got %b, expected 0", ae_w[0]); end
        issue(0, 1'b1, 1'b1, 1'b0, 32'h10, 32'h0, 5'd6, s, b);
        @(negedge clk);
        tests_run++; if ({rd_w[0], ae_w[0]} !== {32'hDEADBEEF, 1'b0}) begin
            tests_failed++; $display("FAIL mis_old_data: got rd=%h ae=%b, expected deadbeef 0", rd_w[0], ae_w[0]); end
        issue(0, 1'b1, 1'b1, 1'b0, 32'h13, 32'h0, 5'd5, s, b);
        @(negedge clk);
        tests_run++; if ({rd_w[0], rw_w[0], m2r_w[0], ae_w[0], wr_w[0]} !== {32'h0, 3'b011, 5'd5}) begin
            tests_failed++; $display("FAIL mis_ld: got rd=%h rw=%b m2r=%b ae=%b wr=%0d, expected 0 0 1 1 5",
                                     rd_w[0], rw_w[0], m2r_w[0], ae_w[0], wr_w[0]); end
    endtask

    task automatic test_wrap();
        int s, b;
        issue(0, 1'b0, 1'b0, 1'b1, 32'h400, 32'hA5A5A5A5, 5'd0, s, b);
        issue(0, 1'b1, 1'b1, 1'b0, 32'h0, 32'h0, 5'd2, s, b);
        @(negedge clk);
        tests_run++; if (rd_w[0] !== 32'hA5A5A5A5) begin tests_failed++; $display("FAIL wrap: got %h, expected a5a5a5a5", rd_w[0]); end
    endtask

    task automatic test_abort();
        int s, b;
        @(posedge clk); #1;
        mw_m[2] = 1'b1; alu_m[2] = 32'h8; wd_m[2] = 32'h77777777;
        @(negedge clk);
        tests_run++; if (stall_m[2] !== 1'b1) begin tests_failed++; $display("FAIL ab_stall0: got %b, expected 1", stall_m[2]); end
        @(negedge clk);
        tests_run++; if ({stall_m[2], busy[2]} !== 2'b11) begin
            tests_failed++; $display("FAIL ab_stall1: got stall=%b busy=%b, expected 1 1", stall_m[2], busy[2]); end
        #1 reset = 1'b1;
        set_nop(2);
        #1;
        tests_run++; if ({stall_m[2], busy[2], rw_w[2], ae_w[2], alu_w[2]} !== '0) begin
            tests_failed++; $display("FAIL ab_reset: got stall=%b busy=%b rw=%b ae=%b alu=%h, expected all 0",
                                     stall_m[2], busy[2], rw_w[2], ae_w[2], alu_w[2]); end
        @(posedge clk); #1 reset = 1'b0;
        issue(2, 1'b1, 1'b1, 1'b0, 32'h8, 32'h0, 5'd4, s, b);
        @(negedge clk);
        tests_run++; if (s !== 2) begin tests_failed++; $display("FAIL ab_ld_stall: got %0d, expected 2", s); end
        tests_run++; if ({rd_w[2], rw_w[2], wr_w[2]} !== {32'h0, 1'b1, 5'd4}) begin
            tests_failed++; $display("FAIL ab_ld: got rd=%h rw=%b wr=%0d, expected 0 1 4", rd_w[2], rw_w[2], wr_w[2]); end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        reset        = 1'b1;
        for (int k = 0; k < 3; k++) set_nop(k);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        test_reset();
        test_store_load();
        test_latency4();
        test_misaligned();
        test_wrap();
        test_abort();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
